vec_dot_acc: RTL
================

# vec_dot_acc

Parametrised, fully pipelined signed dot-product engine with a valid/ready handshake and optional multi-beat accumulation. It supersedes the free-running, counter-based vector multiplier in the processing element. Each beat carries its own valid bit and sideband through the pipeline, the whole pipeline stalls under back-pressure, and dot-products longer than C lanes are built by accumulating beats into a saturating W_ACC-bit result.

## Interface
Parameters:
- C, 8: lanes per beat, ≥1; padded internally to C_PAD = 2^clog2(C) with zero lanes.
- W_X, 8: signed width of each x lane.
- W_K, 8: signed width of each k lane.
- W_ACC, 32: signed accumulator/output width; must be ≥ W_Y. Elaboration error otherwise.
- Derived, not overridable: DEPTH = clog2(C) (0 when C=1), W_M = W_X+W_K, W_Y = W_M+DEPTH.

Ports:
- clk, in, 1: single clock, all state on rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- in_valid, in, 1: beat present on x/k/in_acc/in_last.
- in_ready, out, 1: block accepts a beat this cycle.
- x, in, C×W_X signed packed: data lanes.
- k, in, C×W_K signed packed: coefficient lanes.
- in_acc, in, 1: beat is part of an accumulation group.
- in_last, in, 1: closes an accumulation group; ignored when in_acc=0.
- out_valid, out, 1: result on y/out_ovf.
- out_ready, in, 1: consumer takes the result.
- y, out, W_ACC signed: result.
- out_ovf, out, 1: result was saturated.

## Operation
- Stages: S0 lane multiply (W_M, registered); S1..S_DEPTH pairwise adder levels (one extra bit per level, registered); final accumulate/output stage.
- Each stage carries v, acc and last bits alongside its data. No counter derives validity.
- Global advance: adv = !out_valid || out_ready. in_ready = adv. Every stage, including empty stages, shifts only when adv=1. When adv=0, all registers hold.
- A beat is accepted when in_valid && in_ready.
- The tree sum s (W_Y) is sign-extended to W_ACC.
- Accumulator FSM, evaluated when a valid beat leaves the tree with adv=1:
  - IDLE, acc=0: start the sum with acc_reg = s and clear ovf_reg. If last=1, emit s and stay IDLE. Otherwise go to RUN.
  - RUN, acc=1: acc_reg = sat(acc_reg + s), and ovf_reg |= saturation. If last=1, emit the sum and ovf_reg, then go to IDLE. Otherwise stay in RUN.
  - Either state, acc=0: emit s with ovf=0. The accumulator and FSM state are untouched, so a plain beat may interleave inside a group.
- sat(): the sum is computed at W_ACC+1 bits and clamped to [-2^(W_ACC-1), 2^(W_ACC-1)-1].
- Emitting a result sets out_valid=1 and loads y and out_ovf.
- Output register on adv=1:
  - A non-emitting beat or an empty stage drops out_valid to 0.
  - A valid output with out_ready=0 holds y, out_valid and out_ovf stable.
- Padded lanes contribute exactly 0.

## Timing
- Reset values: out_valid=0, y=0, out_ovf=0, in_ready=1, all stage valid bits 0, acc_reg=0, ovf_reg=0, FSM=IDLE.
- Reset takes effect immediately when asserted. It is legal mid-accumulation or mid-stall: the partial sum and all in-flight beats are discarded.
- Latency: a beat accepted at edge t produces out_valid at edge t+DEPTH+2 with no stall. This is 5 cycles for C=8 and 2 cycles for C=1.
- Throughput: one beat per cycle while out_ready=1.
- Each stall cycle (out_valid && !out_ready) adds exactly one cycle to every in-flight beat. No beat is dropped or duplicated.
- in_ready is combinational from out_valid and out_ready.
- Simultaneous consume and produce (out_ready=1 and a new result arriving at the same edge): the new result replaces the old one. out_valid stays 1.
- The accumulator adds at most one term per cycle. There is no read-modify-write hazard because the accumulator stage is the single writer.

## Test plan
- C=8 single beat: x=1..8, k=1 all lanes, in_acc=0 → y=36, out_ovf=0, out_valid 5 cycles after acceptance for one cycle.
- Extremes, C=8: x=-128, k=-128 all lanes → y=131072. Also x=-128, k=127 → y=-130048.
- Accumulate, C=8: three beats of x=1, k=2 (each s=16), in_acc=1, in_last on the third → one result y=48. No out_valid on beats 1–2.
- Back-pressure: 20-beat stream with out_ready toggling 0/1 randomly, plus a 10-cycle low window → results in order and equal to the model. in_ready low exactly while out_valid && !out_ready.
- Saturation, W_ACC=19, C=8: two accumulated beats with s=131072 each → y=262143, out_ovf=1. The next group starts clean with out_ovf=0.
- Reset mid-group: two accumulated beats, then rst pulse → out_valid=0, y=0. A following single beat (s=36) yields y=36, not carrying the old partial sum. Non-power-of-2 C=5 and C=1 produce model-correct sums with latency DEPTH+2.

Source files
------------

// File: rtl/vec_dot_acc_if.sv
// Beat/result handshake bundle for vec_dot_acc: x/k lanes with accumulation
// sideband in, saturating signed result out, valid/ready on both sides.
interface vec_dot_acc_if #(
   parameter int C     = 8,
   parameter int W_X   = 8,
   parameter int W_K   = 8,
   parameter int W_ACC = 32
);
   logic                    in_valid;
   logic                    in_ready;
   logic [C*W_X-1:0]        x;
   logic [C*W_K-1:0]        k;
   logic                    in_acc;
   logic                    in_last;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [W_ACC-1:0] y;
   logic                    out_ovf;

   modport master (
      output in_valid, x, k, in_acc, in_last, out_ready,
      input  in_ready, out_valid, y, out_ovf
   );

   modport slave (
      input  in_valid, x, k, in_acc, in_last, out_ready,
      output in_ready, out_valid, y, out_ovf
   );
endinterface

// File: rtl/vec_dot_acc.sv
// Pipelined signed dot-product engine: input register, lane multiply, adder tree,
// then a saturating multi-beat accumulator; the whole pipe stalls on back-pressure.
module vec_dot_acc #(
   parameter int C     = 8,
   parameter int W_X   = 8,
   parameter int W_K   = 8,
   parameter int W_ACC = 32
) (
   input  logic         clk,
   input  logic         rst,
   vec_dot_acc_if.slave bus
);
   localparam int DEPTH = (C > 1) ? $clog2(C) : 0;
   localparam int C_PAD = 1 << DEPTH;
   localparam int W_M   = W_X + W_K;
   localparam int W_Y   = W_M + DEPTH;
   localparam int W_W   = W_ACC + 1;
   localparam int NST   = DEPTH + 2;
   localparam int NODES = 2 * C_PAD;

   generate
      if (C < 1 || W_ACC < W_Y) begin : g_param_check
         $error("vec_dot_acc: need C >= 1 and W_ACC >= W_Y");
      end
   endgenerate

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Returns {saturated, clamped a+b}, computed one bit wider than the operands.
   function automatic logic [W_ACC:0] sat_add(input logic signed [W_ACC-1:0] a,
                                              input logic signed [W_ACC-1:0] b);
      logic signed [W_ACC:0] wide;
      logic [W_ACC:0]        res;
      wide = W_W'(a) + W_W'(b);
      if (wide[W_ACC] != wide[W_ACC-1]) begin
         res = {1'b1, wide[W_ACC], {(W_ACC-1){~wide[W_ACC]}}};
      end else begin
         res = {1'b0, wide[W_ACC-1:0]};
      end
      return res;
   endfunction

   logic                    adv_s;
   logic [C*W_X-1:0]        x_q;
   logic [C*W_K-1:0]        k_q;
   logic [NST-1:0]          v_q;
   logic [NST-1:0]          acc_q;
   logic [NST-1:0]          last_q;
   logic signed [W_Y-1:0]   node_q [1:NODES-1];
   logic signed [W_Y-1:0]   node_d [1:NODES-1];

   state_t                  state_q, state_d;
   logic signed [W_ACC-1:0] acc_reg_q, acc_reg_d;
   logic                    ovf_reg_q, ovf_reg_d;
   logic                    out_valid_q, out_valid_d;
   logic signed [W_ACC-1:0] y_q, y_d;
   logic                    out_ovf_q, out_ovf_d;
   logic signed [W_ACC-1:0] s_ext_s;
   logic signed [W_ACC-1:0] sum_s;
   logic                    sat_s;

   assign adv_s         = !out_valid_q || bus.out_ready;
   assign bus.in_ready  = adv_s;
   assign bus.out_valid = out_valid_q;
   assign bus.y         = y_q;
   assign bus.out_ovf   = out_ovf_q;

   // Heap-ordered tree: leaves C_PAD.. hold lane products, node 1 is the full sum.
   generate
      for (genvar g = 0; g < C_PAD; g++) begin : g_lane
         if (g < C) begin : g_mul
            logic signed [W_X-1:0] xl_s;
            logic signed [W_K-1:0] kl_s;
            logic signed [W_M-1:0] prod_s;
            assign xl_s   = x_q[g*W_X +: W_X];
            assign kl_s   = k_q[g*W_K +: W_K];
            assign prod_s = W_M'(xl_s) * W_M'(kl_s);
            assign node_d[C_PAD+g] = W_Y'(prod_s);
         end else begin : g_pad
            assign node_d[C_PAD+g] = '0;
         end
      end
      for (genvar n = 1; n < C_PAD; n++) begin : g_add
         assign node_d[n] = node_q[2*n] + node_q[2*n+1];
      end
   endgenerate

   // Pipeline registers with valid/sideband; everything holds while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q    <= '0;
         k_q    <= '0;
         v_q    <= '0;
         acc_q  <= '0;
         last_q <= '0;
         for (int n = 1; n < NODES; n++) begin
            node_q[n] <= '0;
         end
      end else if (adv_s) begin
         x_q    <= bus.x;
         k_q    <= bus.k;
         v_q    <= {v_q[NST-2:0], bus.in_valid};
         acc_q  <= {acc_q[NST-2:0], bus.in_acc};
         last_q <= {last_q[NST-2:0], bus.in_last};
         node_q <= node_d;
      end
   end

   assign s_ext_s = W_ACC'(node_q[1]);

   // Accumulator FSM and output selection for the beat leaving the tree.
   always_comb begin
      state_d     = state_q;
      acc_reg_d   = acc_reg_q;
      ovf_reg_d   = ovf_reg_q;
      out_valid_d = 1'b0;
      y_d         = y_q;
      out_ovf_d   = out_ovf_q;
      {sat_s, sum_s} = sat_add(acc_reg_q, s_ext_s);
      if (v_q[NST-1]) begin
         if (!acc_q[NST-1]) begin
            out_valid_d = 1'b1;
            y_d         = s_ext_s;
            out_ovf_d   = 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  acc_reg_d = s_ext_s;
                  ovf_reg_d = 1'b0;
                  if (last_q[NST-1]) begin
                     out_valid_d = 1'b1;
                     y_d         = s_ext_s;
                     out_ovf_d   = 1'b0;
                  end else begin
                     state_d = ST_RUN;
                  end
               end
               ST_RUN: begin
                  acc_reg_d = sum_s;
                  ovf_reg_d = ovf_reg_q | sat_s;
                  if (last_q[NST-1]) begin
                     out_valid_d = 1'b1;
                     y_d         = sum_s;
                     out_ovf_d   = ovf_reg_q | sat_s;
                     state_d     = ST_IDLE;
                  end else begin
                     state_d = ST_RUN;
                  end
               end
               default: begin
                  state_d = ST_IDLE;
               end
            endcase
         end
      end else begin
         state_d = state_q;
      end
   end

   // Accumulator state and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         acc_reg_q   <= '0;
         ovf_reg_q   <= 1'b0;
         out_valid_q <= 1'b0;
         y_q         <= '0;
         out_ovf_q   <= 1'b0;
      end else if (adv_s) begin
         state_q     <= state_d;
         acc_reg_q   <= acc_reg_d;
         ovf_reg_q   <= ovf_reg_d;
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
         out_ovf_q   <= out_ovf_d;
      end
   end
endmodule
